spi_master_arbiter: RTL and testbench

- Shares one SPI master (SPIctrl Master side) between N byte-oriented requesters.
- Round-robin arbitration per transaction; a transaction is one or more bytes to one slave-select code.
- Drives toXmit/strobe/ss into the master, waits for Ready and routes Rcvd back to the owning requester.
- Holds slave select across multi-byte bursts; a watchdog aborts a hung transfer.

---
 rtl/spi_arb_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/spi_master_arbiter.sv | 129 ++++++++++++
 tb/tb_spi_master_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and widths for the SPI master arbiter.
package spi_arb_pkg;

    localparam int SS_W   = 2;
    localparam int BYTE_W = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t ISSUE = 2'd1;
    localparam state_t WAIT  = 2'd2;
    localparam state_t HOLD  = 2'd3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request above the previous winner, wrapping.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic found;
    int   cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(last) + k) % N_REQ;
            if (!found && req[IDX_W'(cand)]) begin
                found   = 1'b1;
                gnt_idx = IDX_W'(cand);
            end
        end
        if (found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one SPI master between N_REQ byte requesters, one transaction (burst) at a time.
module spi_master_arbiter
    import spi_arb_pkg::*;
#(
    parameter int              N_REQ   = 2,
    parameter logic [SS_W-1:0] SS_IDLE = 2'b00,
    parameter int              TIMEOUT = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [BYTE_W*N_REQ-1:0]   req_data,
    input  logic [SS_W*N_REQ-1:0]     req_ss,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic [BYTE_W-1:0]         rsp_data,
    output logic                      rsp_err,
    output logic [BYTE_W-1:0]         m_toXmit,
    output logic                      m_strobe,
    output logic [SS_W-1:0]           m_ss,
    input  logic [BYTE_W-1:0]         m_Rcvd,
    input  logic                      m_Ready,
    input  logic                      m_XmitFull,
    input  logic                      m_busy
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int WD_W  = $clog2(TIMEOUT);

    state_t             state_q;
    logic [IDX_W-1:0]   grant_q;
    logic [IDX_W-1:0]   last_grant_q;
    logic               last_q;
    logic [WD_W-1:0]    wd_q;

    logic [N_REQ-1:0]   pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic [SS_W-1:0]    pick_ss;
    logic [BYTE_W-1:0]  cur_data;
    logic               cur_valid;
    logic               cur_last;

    assign pick_ss   = req_ss[SS_W*int'(pick_idx) +: SS_W];
    assign cur_data  = req_data[BYTE_W*int'(grant_q) +: BYTE_W];
    assign cur_valid = req_valid[grant_q];
    assign cur_last  = req_last[grant_q];

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req     (req_valid),
        .last    (last_grant_q),
        .gnt     (pick_oh),
        .gnt_idx (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(N_REQ - 1);
            last_q       <= 1'b0;
            wd_q         <= '0;
            req_ready    <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
            m_toXmit     <= '0;
            m_strobe     <= 1'b0;
            m_ss         <= SS_IDLE;
        end else begin
            req_ready <= '0;
            rsp_valid <= '0;
            m_strobe  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|pick_oh) begin
                        grant_q <= pick_idx;
                        m_ss    <= pick_ss;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!m_XmitFull && !m_busy) begin
                        m_strobe           <= 1'b1;
                        m_toXmit           <= cur_data;
                        req_ready[grant_q] <= 1'b1;
                        last_q             <= cur_last;
                        wd_q               <= '0;
                        state_q            <= WAIT;
                    end
                end
                WAIT: begin
                    // A Ready on the expiry cycle still counts as a normal completion.
                    if (m_Ready) begin
                        rsp_data           <= m_Rcvd;
                        rsp_err            <= 1'b0;
                        rsp_valid[grant_q] <= 1'b1;
                        if (last_q) begin
                            last_grant_q <= grant_q;
                            m_ss         <= SS_IDLE;
                            state_q      <= IDLE;
                        end else begin
                            state_q <= HOLD;
                        end
                    end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                        rsp_data           <= '0;
                        rsp_err            <= 1'b1;
                        rsp_valid[grant_q] <= 1'b1;
                        last_grant_q       <= grant_q;
                        m_ss               <= SS_IDLE;
                        state_q            <= IDLE;
                    end else begin
                        wd_q <= wd_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (cur_valid) begin
                        state_q <= ISSUE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter with a transaction-level reference model.
module tb_spi_master_arbiter;

    localparam int N  = 2;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_last, req_ready, rsp_valid;
    logic [8*N-1:0] req_data;
    logic [2*N-1:0] req_ss;
    logic [7:0]     rsp_data, m_toXmit, m_Rcvd;
    logic           rsp_err, m_strobe, m_Ready, m_XmitFull, m_busy;
    logic [1:0]     m_ss;

    spi_master_arbiter #(
        .N_REQ   (N),
        .SS_IDLE (2'b00),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ss     (req_ss),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_err    (rsp_err),
        .m_toXmit   (m_toXmit),
        .m_strobe   (m_strobe),
        .m_ss       (m_ss),
        .m_Rcvd     (m_Rcvd),
        .m_Ready    (m_Ready),
        .m_XmitFull (m_XmitFull),
        .m_busy     (m_busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] ss;
        logic       last;
    } item_t;

    item_t rq0[$];
    item_t rq1[$];

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;

    // Reference model: what the arbiter owes the outside world, edge by edge.
    int         owner      = -1;
    int         last_owner = N - 1;
    int         strobe_c   = 0;
    bit         in_flight  = 1'b0;
    bit         may_send   = 1'b0;
    bit         cur_last   = 1'b0;
    bit         model_ok   = 1'b0;
    logic [N-1:0] e_ready = '0, e_rsp = '0;
    logic         e_strobe = 1'b0, e_err = 1'b0;
    logic [7:0]   e_tx = '0, e_rd = '0;
    logic [1:0]   e_ss = '0;

    // Inputs as the DUT sampled them on the most recent edge.
    logic           s_rst = 1'b0, s_full = 1'b0, s_busy = 1'b0, s_ready = 1'b0;
    logic [N-1:0]   s_valid = '0, s_last = '0;
    logic [8*N-1:0] s_data = '0;
    logic [2*N-1:0] s_ss = '0;
    logic [7:0]     s_rcvd = '0;

    // Master stand-in.
    int         rdy_delay = 3;
    int         full_cnt  = 0;
    int         m_cnt     = 0;
    bit         m_pend    = 1'b0;
    logic [7:0] m_last_tx = '0;

    int log_own[$], log_scyc[$], log_ss[$], log_tx[$];
    int log_rown[$], log_rcyc[$], log_rd[$], log_rerr[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic int at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic void clear_logs();
        log_own.delete(); log_scyc.delete(); log_ss.delete(); log_tx.delete();
        log_rown.delete(); log_rcyc.delete(); log_rd.delete(); log_rerr.delete();
    endfunction

    task automatic push(input int r, input logic [7:0] d, input logic [1:0] s, input logic l);
        item_t it;
        it = {d, s, l};
        if (r == 0) rq0.push_back(it);
        else rq1.push_back(it);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Compare process: model step, output check, logging, then drive the next inputs.
    initial begin
        forever begin
            @(negedge clk);
            e_ready  = '0;
            e_rsp    = '0;
            e_strobe = 1'b0;
            if (s_rst) begin
                model_ok   = 1'b1;
                owner      = -1;
                last_owner = N - 1;
                in_flight  = 1'b0;
                may_send   = 1'b0;
                e_tx = '0; e_rd = '0; e_err = 1'b0; e_ss = 2'b00;
            end else if (model_ok) begin
                if (owner < 0) begin
                    if (s_valid != '0) begin
                        owner    = rr_pick(s_valid, last_owner);
                        e_ss     = s_ss[2*owner +: 2];
                        may_send = 1'b1;
                    end
                end else if (in_flight) begin
                    if (s_ready || (cyc - strobe_c == TO)) begin
                        e_rsp[owner] = 1'b1;
                        in_flight    = 1'b0;
                        e_err        = !s_ready;
                        e_rd         = s_ready ? s_rcvd : 8'h00;
                        if (!s_ready || cur_last) begin
                            last_owner = owner;
                            owner      = -1;
                            e_ss       = 2'b00;
                        end
                    end
                end else if (may_send) begin
                    if (!s_full && !s_busy) begin
                        e_strobe       = 1'b1;
                        e_ready[owner] = 1'b1;
                        e_tx           = s_data[8*owner +: 8];
                        cur_last       = s_last[owner];
                        in_flight      = 1'b1;
                        strobe_c       = cyc;
                        may_send       = 1'b0;
                    end
                end else if (s_valid[owner]) begin
                    may_send = 1'b1;
                end
            end

            if (model_ok) begin
                chk("req_ready", req_ready, e_ready);
                chk("rsp_valid", rsp_valid, e_rsp);
                chk("m_strobe", m_strobe, e_strobe);
                chk("m_ss", m_ss, e_ss);
                chk("m_toXmit", m_toXmit, e_tx);
                chk("rsp_data", rsp_data, e_rd);
                chk("rsp_err", rsp_err, e_err);
            end

            if (req_ready != '0) begin
                log_own.push_back(req_ready[1] ? 1 : 0);
                log_scyc.push_back(cyc);
                log_ss.push_back(int'(m_ss));
                log_tx.push_back(int'(m_toXmit));
            end
            if (rsp_valid != '0) begin
                log_rown.push_back(rsp_valid[1] ? 1 : 0);
                log_rcyc.push_back(cyc);
                log_rd.push_back(int'(rsp_data));
                log_rerr.push_back(int'(rsp_err));
            end

            m_Ready = 1'b0;
            if (s_rst || rsp_valid != '0) m_pend = 1'b0;
            if (m_strobe) begin
                m_pend    = 1'b1;
                m_cnt     = 0;
                m_last_tx = m_toXmit;
            end
            if (m_pend) begin
                m_cnt++;
                if (rdy_delay != 0 && m_cnt == rdy_delay) begin
                    m_Ready = 1'b1;
                    m_Rcvd  = m_last_tx ^ 8'h99;
                    m_pend  = 1'b0;
                end
            end
            m_busy     = m_pend;
            m_XmitFull = (full_cnt > 0);
            if (full_cnt > 0) full_cnt--;

            if (req_ready[0]) void'(rq0.pop_front());
            if (req_ready[1]) void'(rq1.pop_front());
            req_valid[0] = rq0.size() > 0;
            req_valid[1] = rq1.size() > 0;
            if (rq0.size() > 0) begin
                req_data[7:0] = rq0[0].data; req_ss[1:0] = rq0[0].ss; req_last[0] = rq0[0].last;
            end
            if (rq1.size() > 0) begin
                req_data[15:8] = rq1[0].data; req_ss[3:2] = rq1[0].ss; req_last[1] = rq1[0].last;
            end

            s_rst = rst; s_valid = req_valid; s_data = req_data; s_ss = req_ss; s_last = req_last;
            s_full = m_XmitFull; s_busy = m_busy; s_ready = m_Ready; s_rcvd = m_Rcvd;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic quiet(input string name, input int budget);
        int k;
        k = 0;
        while (!(rq0.size() == 0 && rq1.size() == 0 && owner < 0 && !m_pend) && k < budget) begin
            step(1);
            k++;
        end
        chk({name, " completes"}, k < budget, 1);
        step(2);
    endtask

    initial begin
        #100000;
        $display("FAIL global time limit reached");
        $fatal(1);
    end

    initial begin
        int c0;
        int k;
        rst = 1'b1;
        req_valid = '0; req_data = '0; req_ss = '0; req_last = '0;
        m_Rcvd = '0; m_Ready = 1'b0; m_XmitFull = 1'b0; m_busy = 1'b0;
        step(3);
        rst = 1'b0;
        step(1);
        chk("reset m_ss", m_ss, 2'b00);
        chk("reset m_strobe", m_strobe, 1'b0);
        chk("reset rsp_data", rsp_data, 8'h00);
        chk("reset m_toXmit", m_toXmit, 8'h00);

        // Single byte, Ready three cycles after the strobe.
        clear_logs();
        rdy_delay = 3;
        c0 = cyc;
        push(0, 8'hA5, 2'b01, 1'b1);
        quiet("t1", 40);
        chk("t1 strobe latency", at(log_scyc, 0) - c0, 2);
        chk("t1 owner", at(log_own, 0), 0);
        chk("t1 toXmit", at(log_tx, 0), 8'hA5);
        chk("t1 ss", at(log_ss, 0), 2'b01);
        chk("t1 rsp latency", at(log_rcyc, 0) - at(log_scyc, 0), 3);
        chk("t1 rsp_data", at(log_rd, 0), 8'h3C);
        chk("t1 rsp_err", at(log_rerr, 0), 0);
        chk("t1 rsp owner", at(log_rown, 0), 0);
        chk("t1 ss idle", m_ss, 2'b00);

        // Round robin between two always-valid requesters.
        clear_logs();
        rdy_delay = 2;
        push(0, 8'h11, 2'b01, 1'b1);
        push(0, 8'h12, 2'b01, 1'b1);
        step(1);
        push(1, 8'h21, 2'b10, 1'b1);
        push(1, 8'h22, 2'b10, 1'b1);
        quiet("t2", 80);
        chk("t2 grant0", at(log_own, 0), 0);
        chk("t2 grant1", at(log_own, 1), 1);
        chk("t2 grant2", at(log_own, 2), 0);
        chk("t2 grant3", at(log_own, 3), 1);
        chk("t2 tx1", at(log_tx, 1), 8'h21);
        chk("t2 tx2", at(log_tx, 2), 8'h12);

        // Three-byte burst from requester 0 holds off requester 1.
        clear_logs();
        push(0, 8'h31, 2'b10, 1'b0);
        push(0, 8'h32, 2'b11, 1'b0);
        push(0, 8'h33, 2'b10, 1'b1);
        push(1, 8'h41, 2'b01, 1'b1);
        quiet("t3", 80);
        chk("t3 own0", at(log_own, 0), 0);
        chk("t3 own1", at(log_own, 1), 0);
        chk("t3 own2", at(log_own, 2), 0);
        chk("t3 own3", at(log_own, 3), 1);
        chk("t3 ss byte2", at(log_ss, 1), 2'b10);
        chk("t3 ss req1", at(log_ss, 3), 2'b01);
        chk("t3 rsp byte3", at(log_rd, 2), 8'hAA);
        chk("t3 req1 after burst", at(log_rcyc, 2) < at(log_scyc, 3), 1);

        // XmitFull held for five cycles after the grant.
        clear_logs();
        full_cnt = 6;
        c0 = cyc;
        push(1, 8'h55, 2'b11, 1'b1);
        quiet("t4", 40);
        chk("t4 strobe count", log_scyc.size(), 1);
        chk("t4 strobe latency", at(log_scyc, 0) - c0, 7);
        chk("t4 owner", at(log_own, 0), 1);

        // Watchdog abort, then Ready landing exactly on the expiry cycle.
        clear_logs();
        rdy_delay = 0;
        push(0, 8'h66, 2'b01, 1'b1);
        quiet("t5a", 40);
        chk("t5a rsp latency", at(log_rcyc, 0) - at(log_scyc, 0), 8);
        chk("t5a rsp_err", at(log_rerr, 0), 1);
        chk("t5a rsp_data", at(log_rd, 0), 8'h00);
        chk("t5a ss idle", m_ss, 2'b00);
        clear_logs();
        rdy_delay = 8;
        push(1, 8'h77, 2'b10, 1'b1);
        quiet("t5b", 40);
        chk("t5b rsp latency", at(log_rcyc, 0) - at(log_scyc, 0), 8);
        chk("t5b rsp_err", at(log_rerr, 0), 0);
        chk("t5b rsp_data", at(log_rd, 0), 8'hEE);

        // Reset while a byte is in flight.
        clear_logs();
        rdy_delay = 0;
        push(0, 8'h88, 2'b01, 1'b1);
        k = 0;
        while (log_scyc.size() == 0 && k < 20) begin
            step(1);
            k++;
        end
        chk("t6 strobe seen", k < 20, 1);
        step(2);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("t6 reset m_ss", m_ss, 2'b00);
        chk("t6 reset rsp_valid", rsp_valid, 2'b00);
        chk("t6 reset m_toXmit", m_toXmit, 8'h00);
        step(12);
        chk("t6 no response", log_rcyc.size(), 0);
        clear_logs();
        rdy_delay = 2;
        push(0, 8'h91, 2'b01, 1'b1);
        push(1, 8'h92, 2'b10, 1'b1);
        quiet("t6", 60);
        chk("t6 first grant", at(log_own, 0), 0);
        chk("t6 second grant", at(log_own, 1), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
